// File: rtl/hub75_capture_if.sv
// Row-write port of the HUB75 capture block: one framebuffer row per valid/ready handshake.
interface hub75_capture_if #(
    parameter int COLS   = 64,
    parameter int ADDR_W = 4
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_W:0]       wr_row;
    logic [3*COLS-1:0]     wr_data;

    modport master (output wr_valid, output wr_row, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_row, input wr_data, output wr_ready);
endinterface

// File: rtl/hub75_capture.sv
// Oversampling HUB75 receiver: rebuilds each latched 64-pixel row pair and writes both rows
// out over a valid/ready port, flagging short/long rows, address skips and write overflow.
module hub75_capture #(
    parameter int COLS        = 64,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hub_clk,
    input  logic        hub_lat,
    input  logic        hub_a,
    input  logic        hub_b,
    input  logic        hub_c,
    input  logic        hub_d,
    input  logic        hub_r0,
    input  logic        hub_g0,
    input  logic        hub_b0,
    input  logic        hub_r1,
    input  logic        hub_g1,
    input  logic        hub_b1,
    hub75_capture_if.master wr,
    output logic        frame_done,
    output logic        len_err,
    output logic        seq_err,
    output logic        ovf_err,
    output logic [15:0] frame_cnt
);
    localparam int CW    = $clog2(COLS + 2);
    localparam int IDX_W = $clog2(COLS);
    localparam logic [CW-1:0]     COL_FULL = CW'(COLS);
    localparam logic [CW-1:0]     COL_SAT  = CW'(COLS + 1);
    localparam logic [CW-1:0]     COL_ONE  = CW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, WR_UP, WR_LO} state_t;

    logic [11:0]                        bus_raw;
    logic [SYNC_STAGES-1:0][11:0]       sync_reg;
    logic                               clk_prev_reg, lat_prev_reg;
    logic [CW-1:0]                      col_reg;
    logic [COLS-1:0][2:0]               upper_reg, lower_reg;
    logic [3*COLS-1:0]                  lower_hold_reg;
    logic [ADDR_W-1:0]                  addr_reg, last_addr_reg;
    logic                               first_reg;
    state_t                             state_reg;

    logic              s_clk, s_lat, clk_rise, lat_rise, hs, busy, len_bad, accept;
    logic [3:0]        s_addr_pins;
    logic [ADDR_W-1:0] s_addr, next_addr;
    logic [2:0]        s_up, s_lo;
    logic [CW-1:0]     wcol;

    assign bus_raw = {hub_clk, hub_lat, hub_d, hub_c, hub_b, hub_a,
                      hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1};

    assign s_clk       = sync_reg[SYNC_STAGES-1][11];
    assign s_lat       = sync_reg[SYNC_STAGES-1][10];
    assign s_addr_pins = sync_reg[SYNC_STAGES-1][9:6];
    assign s_addr      = s_addr_pins[ADDR_W-1:0];
    assign s_up        = sync_reg[SYNC_STAGES-1][5:3];
    assign s_lo        = sync_reg[SYNC_STAGES-1][2:0];

    assign clk_rise  = s_clk & ~clk_prev_reg;
    assign lat_rise  = s_lat & ~lat_prev_reg;
    assign hs        = wr.wr_valid & wr.wr_ready;
    // The hold buffer frees up in the same cycle the lower row is handed off.
    assign busy      = (state_reg != IDLE) && !(state_reg == WR_LO && hs);
    assign len_bad   = lat_rise && (col_reg != COL_FULL);
    assign accept    = lat_rise && !len_bad && !busy;
    assign wcol      = lat_rise ? '0 : col_reg;
    assign next_addr = last_addr_reg + ADDR_ONE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_reg       <= '0;
            clk_prev_reg   <= 1'b0;
            lat_prev_reg   <= 1'b0;
            col_reg        <= '0;
            state_reg      <= IDLE;
            wr.wr_valid    <= 1'b0;
            wr.wr_row      <= '0;
            wr.wr_data     <= '0;
            frame_done     <= 1'b0;
            len_err        <= 1'b0;
            seq_err        <= 1'b0;
            ovf_err        <= 1'b0;
            frame_cnt      <= '0;
            first_reg      <= 1'b1;
            last_addr_reg  <= '0;
            addr_reg       <= '0;
            lower_hold_reg <= '0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], bus_raw};
            clk_prev_reg <= s_clk;
            lat_prev_reg <= s_lat;
            frame_done   <= 1'b0;
            seq_err      <= 1'b0;
            len_err      <= len_bad;
            ovf_err      <= lat_rise && !len_bad && busy;

            // A shift coinciding with a latch becomes column 0 of the next row.
            if (clk_rise && wcol < COL_FULL) begin
                upper_reg[wcol[IDX_W-1:0]] <= s_up;
                lower_reg[wcol[IDX_W-1:0]] <= s_lo;
            end
            if (lat_rise)
                col_reg <= clk_rise ? COL_ONE : '0;
            else if (clk_rise && col_reg != COL_SAT)
                col_reg <= col_reg + COL_ONE;

            case (state_reg)
                WR_UP: if (hs) begin
                    wr.wr_row  <= {1'b1, addr_reg};
                    wr.wr_data <= lower_hold_reg;
                    state_reg  <= WR_LO;
                end
                WR_LO: if (hs) begin
                    wr.wr_valid <= 1'b0;
                    state_reg   <= IDLE;
                    if (&addr_reg) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                    end
                end
                default: ;
            endcase

            if (accept) begin
                wr.wr_valid    <= 1'b1;
                wr.wr_row      <= {1'b0, s_addr};
                wr.wr_data     <= upper_reg;
                lower_hold_reg <= lower_reg;
                addr_reg       <= s_addr;
                state_reg      <= WR_UP;
                first_reg      <= 1'b0;
                last_addr_reg  <= s_addr;
                if (!first_reg && s_addr != next_addr)
                    seq_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hub75_capture.sv
// Scoreboard bench for hub75_capture: stimulus pushes expected row writes, a monitor pops them.
module tb_hub75_capture;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic hub_clk, hub_lat, hub_a, hub_b, hub_c, hub_d;
    logic hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
    logic frame_done, len_err, seq_err, ovf_err;
    logic [15:0] frame_cnt;

    hub75_capture_if #(.COLS(64), .ADDR_W(4)) wr ();

    hub75_capture #(.COLS(64), .ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .hub_clk(hub_clk), .hub_lat(hub_lat),
        .hub_a(hub_a), .hub_b(hub_b), .hub_c(hub_c), .hub_d(hub_d),
        .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
        .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
        .wr(wr),
        .frame_done(frame_done), .len_err(len_err), .seq_err(seq_err), .ovf_err(ovf_err),
        .frame_cnt(frame_cnt)
    );

    typedef struct packed {
        logic [4:0]   row;
        logic [191:0] data;
    } wr_t;

    wr_t exp_q[$];
    int compared = 0;
    int mismatched = 0;
    int len_cnt = 0, seq_cnt = 0, ovf_cnt = 0, fd_cnt = 0;
    int cyc = 0, prev_hs = 0, last_gap = 0;

    task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [191:0] mkpat(input int k, input int m);
        logic [191:0] p;
        p = '0;
        for (int c = 0; c < 64; c++) p[3*c +: 3] = 3'((c * m + k) % 8);
        return p;
    endfunction

    // Monitor: counts status pulses and checks every accepted write against the queue.
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (len_err)    len_cnt++;
                if (seq_err)    seq_cnt++;
                if (ovf_err)    ovf_cnt++;
                if (frame_done) fd_cnt++;
                if (wr.wr_valid && wr.wr_ready) begin
                    last_gap = cyc - prev_hs;
                    prev_hs  = cyc;
                    $display("write row=%0d data=%0h", wr.wr_row, wr.wr_data);
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_write: got row %0d, expected no write", wr.wr_row);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_row", 192'(wr.wr_row), 192'(e.row));
                        check("wr_data", wr.wr_data, e.data);
                    end
                end
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        {hub_clk, hub_lat, hub_a, hub_b, hub_c, hub_d} = '0;
        {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1} = '0;
        ticks(3);
        exp_q.delete();
        rst = 1'b1;
        ticks(2);
    endtask

    task automatic send_row(input int addr, input int n, input logic [191:0] up, input logic [191:0] lo);
        for (int c = 0; c < n; c++) begin
            if (c < 64) begin
                {hub_r0, hub_g0, hub_b0} = up[3*c +: 3];
                {hub_r1, hub_g1, hub_b1} = lo[3*c +: 3];
            end else begin
                {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1} = '0;
            end
            hub_clk = 1'b0;
            ticks(2);
            hub_clk = 1'b1;
            ticks(2);
        end
        hub_clk = 1'b0;
        {hub_d, hub_c, hub_b, hub_a} = 4'(addr);
        ticks(2);
        hub_lat = 1'b1;
        ticks(2);
        hub_lat = 1'b0;
        ticks(6);
        $display("sent row pair addr=%0d cols=%0d", addr, n);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            ticks(1);
        end
        check(name, 192'(exp_q.size()), 192'd0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [191:0] up, lo;
        int base_len, base_seq, base_ovf, base_fd;

        wr.wr_ready = 1'b1;
        do_reset();
        check("rst_valid", 192'(wr.wr_valid), 192'd0);
        check("rst_row", 192'(wr.wr_row), 192'd0);
        check("rst_data", wr.wr_data, 192'd0);
        check("rst_pulses", 192'({frame_done, len_err, seq_err, ovf_err}), 192'd0);
        check("rst_frame_cnt", 192'(frame_cnt), 192'd0);

        // 1: solid red upper, solid blue lower, address 5
        up = {64{3'b100}};
        lo = {64{3'b001}};
        base_len = len_cnt; base_seq = seq_cnt; base_ovf = ovf_cnt;
        exp_q.push_back('{row: 5'd5, data: up});
        exp_q.push_back('{row: 5'd21, data: lo});
        send_row(5, 64, up, lo);
        drain("t1_drain");
        check("t1_consecutive", 192'(last_gap), 192'd1);
        check("t1_errors", 192'((len_cnt - base_len) + (seq_cnt - base_seq) + (ovf_cnt - base_ovf)), 192'd0);

        // 2: two full frames
        do_reset();
        base_seq = seq_cnt; base_fd = fd_cnt;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 16; k++) begin
                exp_q.push_back('{row: 5'(k), data: mkpat(k, 1)});
                exp_q.push_back('{row: 5'(k + 16), data: mkpat(k, 3)});
                send_row(k, 64, mkpat(k, 1), mkpat(k, 3));
            end
            drain("t2_drain");
            ticks(4);
            check("t2_frame_cnt", 192'(frame_cnt), 192'(pass + 1));
            check("t2_frame_done", 192'(fd_cnt - base_fd), 192'(pass + 1));
        end
        check("t2_seq", 192'(seq_cnt - base_seq), 192'd0);

        // 6: reset in WR_LO with wr_ready low abandons the lower row
        base_seq = seq_cnt;
        wr.wr_ready = 1'b0;
        exp_q.push_back('{row: 5'd7, data: mkpat(7, 5)});
        send_row(7, 64, mkpat(7, 5), mkpat(7, 6));
        for (int i = 0; i < 50; i++) begin
            if (wr.wr_valid) break;
            ticks(1);
        end
        check("t6_valid_up", 192'(wr.wr_valid), 192'd1);
        check("t6_seq_skip", 192'(seq_cnt - base_seq), 192'd1);
        wr.wr_ready = 1'b1;
        ticks(1);
        wr.wr_ready = 1'b0;
        check("t6_in_lo_row", 192'(wr.wr_row), 192'd23);
        rst = 1'b0;
        ticks(1);
        rst = 1'b1;
        check("t6_rst_valid", 192'(wr.wr_valid), 192'd0);
        check("t6_rst_frame_cnt", 192'(frame_cnt), 192'd0);
        check("t6_rst_row", 192'(wr.wr_row), 192'd0);
        check("t6_rst_data", wr.wr_data, 192'd0);
        wr.wr_ready = 1'b1;
        base_seq = seq_cnt;
        exp_q.push_back('{row: 5'd9, data: mkpat(9, 2)});
        exp_q.push_back('{row: 5'd25, data: mkpat(9, 7)});
        send_row(9, 64, mkpat(9, 2), mkpat(9, 7));
        drain("t6_drain");
        check("t6_seq_after_rst", 192'(seq_cnt - base_seq), 192'd0);

        // 3: short and long rows
        base_len = len_cnt;
        send_row(2, 63, mkpat(1, 1), mkpat(2, 1));
        check("t3_len_short", 192'(len_cnt - base_len), 192'd1);
        send_row(2, 70, mkpat(3, 1), mkpat(4, 1));
        ticks(20);
        check("t3_len_total", 192'(len_cnt - base_len), 192'd2);
        check("t3_no_valid", 192'(wr.wr_valid), 192'd0);

        // 4: overflow while the sink stalls
        do_reset();
        base_ovf = ovf_cnt; base_seq = seq_cnt;
        wr.wr_ready = 1'b0;
        exp_q.push_back('{row: 5'd3, data: mkpat(3, 9)});
        exp_q.push_back('{row: 5'd19, data: mkpat(3, 11)});
        send_row(3, 64, mkpat(3, 9), mkpat(3, 11));
        send_row(4, 64, mkpat(4, 9), mkpat(4, 11));
        check("t4_hold_valid", 192'(wr.wr_valid), 192'd1);
        check("t4_hold_row", 192'(wr.wr_row), 192'd3);
        check("t4_hold_data", wr.wr_data, mkpat(3, 9));
        check("t4_ovf", 192'(ovf_cnt - base_ovf), 192'd1);
        wr.wr_ready = 1'b1;
        drain("t4_drain");
        ticks(10);
        check("t4_seq", 192'(seq_cnt - base_seq), 192'd0);

        // 5: address skip 1 -> 3
        do_reset();
        base_seq = seq_cnt;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{row: 5'(k), data: mkpat(k, 13)});
            exp_q.push_back('{row: 5'(k + 16), data: mkpat(k, 15)});
            send_row(k, 64, mkpat(k, 13), mkpat(k, 15));
        end
        check("t5_seq_before", 192'(seq_cnt - base_seq), 192'd0);
        exp_q.push_back('{row: 5'd3, data: mkpat(3, 13)});
        exp_q.push_back('{row: 5'd19, data: mkpat(3, 15)});
        send_row(3, 64, mkpat(3, 13), mkpat(3, 15));
        drain("t5_drain");
        check("t5_seq_after", 192'(seq_cnt - base_seq), 192'd1);

        ticks(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
